// File: rtl/branch_predict_ctrl.sv
// Fetch-stage BTB predictor (direct-mapped, 2-bit counters) and execute-stage redirect/update control.
// Optional build macro BP_STATS_EN adds saturating resolved-branch and mispredict counters.
module branch_predict_ctrl #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned IDX_W = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] PCF,
    output logic            PredTakenF,
    output logic [XLEN-1:0] PredTargetF,
    output logic            InitBusy,
    input  logic            BranchE,
    input  logic            JumpE,
    input  logic            JalrE,
    input  logic [1:0]      PCSrcE,
    input  logic [XLEN-1:0] PCE,
    input  logic [XLEN-1:0] PCTargetE,
    input  logic [XLEN-1:0] ALUResultE,
    input  logic            PredTakenE,
    input  logic [XLEN-1:0] PredTargetE,
    output logic            RedirectE,
    output logic [XLEN-1:0] RedirectPCE,
    output logic            FlushD,
    output logic            FlushE,
    output logic [31:0]     BrCount,
    output logic [31:0]     MissCount
);

    localparam int unsigned DEPTH = 2 ** IDX_W;
    localparam int unsigned TAG_W = XLEN - IDX_W - 2;

    localparam logic [0:0] S_INIT = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    logic             valid_q  [DEPTH];
    logic             valid_d  [DEPTH];
    logic [TAG_W-1:0] tag_q    [DEPTH];
    logic [TAG_W-1:0] tag_d    [DEPTH];
    logic [XLEN-1:0]  target_q [DEPTH];
    logic [XLEN-1:0]  target_d [DEPTH];
    logic [1:0]       ctr_q    [DEPTH];
    logic [1:0]       ctr_d    [DEPTH];

    logic             run;
    logic [IDX_W-1:0] f_idx, e_idx;
    logic [TAG_W-1:0] f_tag, e_tag;
    logic             f_hit, e_hit;
    logic             cf_active;
    logic             taken;
    logic [XLEN-1:0]  tgt;

    // PC bits [1:0] never select an entry and bit 0 of the jalr sum is always cleared.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{PCF[1:0], PCE[1:0], ALUResultE[0]};

    assign run      = (state_q == S_RUN);
    assign InitBusy = (state_q == S_INIT);

    assign f_idx = PCF[IDX_W+1:2];
    assign f_tag = PCF[XLEN-1:IDX_W+2];
    assign e_idx = PCE[IDX_W+1:2];
    assign e_tag = PCE[XLEN-1:IDX_W+2];

    assign f_hit = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
    assign e_hit = valid_q[e_idx] && (tag_q[e_idx] == e_tag);

    always_comb begin
        PredTakenF  = run && f_hit && ctr_q[f_idx][1];
        PredTargetF = PredTakenF ? target_q[f_idx] : '0;
    end

    assign cf_active = run && (BranchE || JumpE || JalrE);
    assign taken     = (PCSrcE != 2'b00);
    assign tgt       = JalrE ? {ALUResultE[XLEN-1:1], 1'b0} : PCTargetE;

    always_comb begin
        RedirectE   = cf_active && ((PredTakenE != taken) || (taken && (PredTargetE != tgt)));
        RedirectPCE = '0;
        if (RedirectE) begin
            RedirectPCE = taken ? tgt : (PCE + XLEN'(4));
        end
    end

    assign FlushD = RedirectE;
    assign FlushE = RedirectE;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        ctr_d    = ctr_q;
        if (state_q == S_INIT) begin
            valid_d[idx_q] = 1'b0;
            idx_d          = idx_q + IDX_W'(1);
            if (idx_q == '1) begin
                state_d = S_RUN;
            end
        end else if (cf_active) begin
            // jalr takes priority and never touches the table.
            if (JumpE && !JalrE) begin
                valid_d[e_idx]  = 1'b1;
                tag_d[e_idx]    = e_tag;
                target_d[e_idx] = tgt;
                ctr_d[e_idx]    = 2'b11;
            end else if (BranchE && !JalrE && !JumpE) begin
                if (e_hit) begin
                    if (taken) begin
                        target_d[e_idx] = tgt;
                        if (ctr_q[e_idx] != 2'b11) begin
                            ctr_d[e_idx] = ctr_q[e_idx] + 2'd1;
                        end
                    end else if (ctr_q[e_idx] != 2'b00) begin
                        ctr_d[e_idx] = ctr_q[e_idx] - 2'd1;
                    end
                end else if (taken) begin
                    valid_d[e_idx]  = 1'b1;
                    tag_d[e_idx]    = e_tag;
                    target_d[e_idx] = tgt;
                    ctr_d[e_idx]    = 2'b10;
                end
            end
        end
    end

    // Reset wins over any pending update; stale entries are wiped by the INIT sweep.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_INIT;
            idx_q   <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            valid_q  <= valid_d;
            tag_q    <= tag_d;
            target_q <= target_d;
            ctr_q    <= ctr_d;
        end
    end

`ifdef BP_STATS_EN
    logic [31:0] br_count_q, br_count_d;
    logic [31:0] miss_count_q, miss_count_d;

    always_comb begin
        br_count_d   = br_count_q;
        miss_count_d = miss_count_q;
        if (cf_active && (br_count_q != '1)) begin
            br_count_d = br_count_q + 32'd1;
        end
        if (RedirectE && (miss_count_q != '1)) begin
            miss_count_d = miss_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            br_count_q   <= '0;
            miss_count_q <= '0;
        end else begin
            br_count_q   <= br_count_d;
            miss_count_q <= miss_count_d;
        end
    end

    assign BrCount   = br_count_q;
    assign MissCount = miss_count_q;
`else
    assign BrCount   = '0;
    assign MissCount = '0;
`endif

endmodule
